mapa_scheduler: RTL and testbench

- Time-multiplexing scheduler for the shared 7-bit display path that selects between two pattern maps (mapa0/mapa1).
- Two requesters each present a 7-bit map and a request line; the block arbitrates round-robin with a fixed dwell time per slot.
- It drives the map-select line and a registered 7-bit output to the display.
- It shows a blank pattern when neither requester is active.

---
 rtl/mapa_scheduler.sv | 122 ++++++++++++
 tb/tb_mapa_scheduler.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mapa_scheduler.sv
// Round-robin time-multiplexer of two 7-bit patterns onto one display path.
// All outputs are registered from next-state (1-cycle latency); hold freezes the dwell counter and blocks only expiry-based switching.
module mapa_scheduler #(
    parameter int         DWELL = 4,
    parameter int         CNT_W = 16,
    parameter logic [6:0] BLANK = 7'b1111111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [6:0] mapa0,
    input  logic [6:0] mapa1,
    input  logic       hold,
    output logic       sel,
    output logic [6:0] out,
    output logic       grant0,
    output logic       grant1,
    output logic       slot_tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW0 = 2'd1,
        SHOW1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last, last_nxt;
    logic             tick_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            sel       <= 1'b0;
            out       <= BLANK;
            grant0    <= 1'b0;
            grant1    <= 1'b0;
            slot_tick <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            slot_tick <= tick_nxt;
            grant0    <= (state_nxt == SHOW0);
            grant1    <= (state_nxt == SHOW1);
            // sel keeps its previous value while idle
            if (state_nxt == SHOW0)
                sel <= 1'b0;
            else if (state_nxt == SHOW1)
                sel <= 1'b1;
            out <= (state_nxt == SHOW0) ? mapa0 :
                   (state_nxt == SHOW1) ? mapa1 : BLANK;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0 && req1)
                    state_nxt = last ? SHOW0 : SHOW1;
                else if (req0)
                    state_nxt = SHOW0;
                else if (req1)
                    state_nxt = SHOW1;
                else
                    state_nxt = IDLE;
            end
            SHOW0: begin
                // losing the request takes priority over dwell and hold
                if (!req0) begin
                    cnt_nxt   = '0;
                    state_nxt = req1 ? SHOW1 : IDLE;
                end else if (!hold) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        tick_nxt  = 1'b1;
                        state_nxt = req1 ? SHOW1 : SHOW0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            SHOW1: begin
                if (!req1) begin
                    cnt_nxt   = '0;
                    state_nxt = req0 ? SHOW0 : IDLE;
                end else if (!hold) begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        tick_nxt  = 1'b1;
                        state_nxt = req0 ? SHOW0 : SHOW1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        last_nxt = last;
        if (state_nxt == SHOW0 && state != SHOW0)
            last_nxt = 1'b0;
        else if (state_nxt == SHOW1 && state != SHOW1)
            last_nxt = 1'b1;
    end

endmodule

// File: tb/tb_mapa_scheduler.sv
// Directed bench for mapa_scheduler with DWELL=4.
module tb_mapa_scheduler;

    logic       clk;
    logic       reset;
    logic       req0, req1, hold;
    logic [6:0] mapa0, mapa1;
    logic       sel, grant0, grant1, slot_tick;
    logic [6:0] out;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] PAT0  = 7'b1000001;
    localparam logic [6:0] PAT1  = 7'b1100011;
    localparam logic [6:0] PAT0B = 7'b0100010;

    mapa_scheduler #(.DWELL(4), .CNT_W(16), .BLANK(7'b1111111)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .mapa0     (mapa0),
        .mapa1     (mapa1),
        .hold      (hold),
        .sel       (sel),
        .out       (out),
        .grant0    (grant0),
        .grant1    (grant1),
        .slot_tick (slot_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic g0, input logic g1,
                           input logic s, input logic [6:0] o, input logic t);
        chk({tag, ".grant0"}, {7'b0, grant0}, {7'b0, g0});
        chk({tag, ".grant1"}, {7'b0, grant1}, {7'b0, g1});
        chk({tag, ".sel"},    {7'b0, sel},    {7'b0, s});
        chk({tag, ".out"},    {1'b0, out},    {1'b0, o});
        chk({tag, ".tick"},   {7'b0, slot_tick}, {7'b0, t});
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; hold = 1'b0;
        mapa0 = PAT0; mapa1 = PAT1;
        cyc(2);
        chk_all("reset", 1'b0, 1'b0, 1'b0, BLANK, 1'b0);
        reset = 1'b0;

        // 1: reset mid-slot in SHOW1 with counter=2
        req1 = 1'b1;
        cyc(1);
        chk_all("t1_show1", 1'b0, 1'b1, 1'b1, PAT1, 1'b0);
        cyc(2);
        reset = 1'b1;
        #1;
        chk_all("t1_async_rst", 1'b0, 1'b0, 1'b0, BLANK, 1'b0);
        #1;
        reset = 1'b0; req1 = 1'b0;
        cyc(2);
        chk_all("t1_idle", 1'b0, 1'b0, 1'b0, BLANK, 1'b0);

        // 2: single requester, tick every 4 cycles, no switch
        req0 = 1'b1;
        cyc(1);
        chk_all("t2_grant", 1'b1, 1'b0, 1'b0, PAT0, 1'b0);
        cyc(3);
        chk_all("t2_pre_exp", 1'b1, 1'b0, 1'b0, PAT0, 1'b0);
        cyc(1);
        chk_all("t2_expiry", 1'b1, 1'b0, 1'b0, PAT0, 1'b1);
        cyc(1);
        chk("t2_tick_end", {7'b0, slot_tick}, 8'd0);
        mapa0 = PAT0B;
        cyc(1);
        chk("t2_map_change", {1'b0, out}, {1'b0, PAT0B});
        req0 = 1'b0; mapa0 = PAT0;
        cyc(1);
        chk_all("t2_drop_idle", 1'b0, 1'b0, 1'b0, BLANK, 1'b0);

        // 6: requester 0 served last, tie goes to requester 1
        req0 = 1'b1; req1 = 1'b1;
        cyc(1);
        chk_all("t6_tie", 1'b0, 1'b1, 1'b1, PAT1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        cyc(1);
        chk_all("t6_idle", 1'b0, 1'b0, 1'b1, BLANK, 1'b0);

        // 3: alternation, requester 1 served last so requester 0 first
        req0 = 1'b1; req1 = 1'b1;
        cyc(1);
        chk_all("t3_show0", 1'b1, 1'b0, 1'b0, PAT0, 1'b0);
        cyc(3);
        chk_all("t3_show0_end", 1'b1, 1'b0, 1'b0, PAT0, 1'b0);
        cyc(1);
        chk_all("t3_sw1", 1'b0, 1'b1, 1'b1, PAT1, 1'b1);
        cyc(3);
        chk_all("t3_show1_end", 1'b0, 1'b1, 1'b1, PAT1, 1'b0);
        cyc(1);
        chk_all("t3_sw0", 1'b1, 1'b0, 1'b0, PAT0, 1'b1);

        // 4: hold for 10 cycles at counter=1 of SHOW0
        cyc(1);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("t4_hold_sel",  {7'b0, sel}, 8'd0);
            chk("t4_hold_tick", {7'b0, slot_tick}, 8'd0);
        end
        hold = 1'b0;
        cyc(2);
        chk_all("t4_remaining", 1'b1, 1'b0, 1'b0, PAT0, 1'b0);
        cyc(1);
        chk_all("t4_sw1", 1'b0, 1'b1, 1'b1, PAT1, 1'b1);

        // 5: drop req0 at counter=1 of SHOW0, then drop req1
        cyc(4);
        chk_all("t5_show0", 1'b1, 1'b0, 1'b0, PAT0, 1'b1);
        cyc(1);
        req0 = 1'b0;
        cyc(1);
        chk_all("t5_drop0", 1'b0, 1'b1, 1'b1, PAT1, 1'b0);
        cyc(3);
        chk("t5_cnt_cleared", {7'b0, slot_tick}, 8'd0);
        cyc(1);
        chk_all("t5_solo_exp", 1'b0, 1'b1, 1'b1, PAT1, 1'b1);
        req1 = 1'b0;
        cyc(1);
        chk_all("t5_idle", 1'b0, 1'b0, 1'b1, BLANK, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
